// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared types and the walking-bit pattern used by both writer and read-back checker
package mem_test_pkg;
  typedef enum logic {MODE_WALK_ONES = 1'b0, MODE_WALK_ZEROS = 1'b1} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;
  // Callers truncate to their data width; bit_idx must stay below that width.
  function automatic logic [63:0] pattern(input logic [5:0] bit_idx, input mode_e mode);
    logic [63:0] one_hot;
    one_hot = 64'd1 << bit_idx;
    return mode == MODE_WALK_ZEROS ? ~one_hot : one_hot;
  endfunction
endpackage

// File: rtl/comparator.sv
// comparator: unsigned equality, less-than and zero flags for two operands
module comparator #(
  parameter int p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] i_DIN0,
  input  logic [p_WIDTH-1:0] i_DIN1,
  output logic               o_EQUAL,
  output logic               o_LESS,
  output logic               o_ZERO
);
  assign o_EQUAL = i_DIN0 == i_DIN1;
  assign o_LESS  = i_DIN0 < i_DIN1;
  assign o_ZERO  = i_DIN0 == '0;
endmodule

// File: rtl/mem_pattern_writer.sv
// mem_pattern_writer: writes a walking-ones/zeros pattern to addresses 0..last over a valid/ready port
module mem_pattern_writer
  import mem_test_pkg::*;
#(
  parameter int p_ADDR_WIDTH = 8,
  parameter int p_DATA_WIDTH = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_START,
  input  logic                    i_MODE,
  input  logic [p_ADDR_WIDTH-1:0] i_ADDR_LAST,
  input  logic                    i_READY,
  output logic                    o_WE,
  output logic [p_ADDR_WIDTH-1:0] o_ADDR,
  output logic [p_DATA_WIDTH-1:0] o_DATA,
  output logic                    o_BUSY,
  output logic                    o_DONE
);
  localparam int BW = p_DATA_WIDTH > 1 ? $clog2(p_DATA_WIDTH) : 1;
  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [p_ADDR_WIDTH-1:0] last_q, last_d, addr_q, addr_d;
  logic [BW-1:0]           bit_q, bit_d, bit_nx;
  logic [p_DATA_WIDTH-1:0] data_q, data_d;
  logic                    at_last, cmp_unused_less, cmp_unused_zero;

  comparator #(.p_WIDTH(p_ADDR_WIDTH)) u_cmp (
    .i_DIN0 (addr_q),
    .i_DIN1 (last_q),
    .o_EQUAL(at_last),
    .o_LESS (cmp_unused_less),
    .o_ZERO (cmp_unused_zero)
  );

  // Bit index tracks address mod data width without a divider.
  assign bit_nx = bit_q == BW'(p_DATA_WIDTH - 1) ? '0 : bit_q + 1'b1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    last_d  = last_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: if (i_START) begin
        state_d = S_WRITE;
        mode_d  = mode_e'(i_MODE);
        last_d  = i_ADDR_LAST;
        addr_d  = '0;
        bit_d   = '0;
        data_d  = p_DATA_WIDTH'(pattern(6'd0, mode_e'(i_MODE)));
      end
      S_WRITE: if (i_READY) begin
        if (at_last) state_d = S_DONE;
        else begin
          addr_d = addr_q + 1'b1;
          bit_d  = bit_nx;
          data_d = p_DATA_WIDTH'(pattern(6'(bit_nx), mode_q));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_WALK_ONES;
      last_q  <= '0;
      addr_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  assign o_WE   = state_q == S_WRITE;
  assign o_BUSY = state_q == S_WRITE;
  assign o_DONE = state_q == S_DONE;
  assign o_ADDR = addr_q;
  assign o_DATA = data_q;
endmodule

// File: tb/tb_mem_pattern_writer.sv
// tb_mem_pattern_writer: randomized scenarios checked against an address-indexed pattern model
module tb_mem_pattern_writer;
  logic       i_CLK = 0, i_RST = 1, i_START = 0, i_MODE = 0, i_READY = 0;
  logic [7:0] i_ADDR_LAST = 0;
  logic       o_WE, o_BUSY, o_DONE;
  logic [7:0] o_ADDR, o_DATA;
  int         tests = 0, fails = 0;

  mem_pattern_writer #(.p_ADDR_WIDTH(8), .p_DATA_WIDTH(8)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START), .i_MODE(i_MODE),
    .i_ADDR_LAST(i_ADDR_LAST), .i_READY(i_READY), .o_WE(o_WE), .o_ADDR(o_ADDR),
    .o_DATA(o_DATA), .o_BUSY(o_BUSY), .o_DONE(o_DONE)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  function automatic logic [7:0] model_pat(input logic mode, input int addr);
    logic [7:0] v;
    v = 8'h01 << (addr % 8);
    return mode ? ~v : v;
  endfunction

  task automatic check_idle_zero(input string name);
    tests++;
    if ({o_WE, o_BUSY, o_DONE, o_ADDR, o_DATA} !== 19'd0) begin
      fails++;
      $display("FAIL %s: we=%b busy=%b done=%b addr=%h data=%h, required all zero", name, o_WE, o_BUSY, o_DONE, o_ADDR, o_DATA);
    end
  endtask

  // rmode: 0 ready always, 1 ready alternating (low first), 2 random ready
  task automatic run_seq(input logic mode, input logic [7:0] last, input int rmode,
                         input bit chaos, input bit keep_start, input string name);
    int  idx, cyc, wes, busys;
    bit  seen_done, alt;
    i_START = 1; i_MODE = mode; i_ADDR_LAST = last; i_READY = 0;
    step();
    i_START = keep_start;
    idx = 0; cyc = 0; wes = 0; busys = 0; seen_done = 0; alt = 0;
    tests++;
    if (o_WE !== 1'b1) begin
      fails++; $display("FAIL %s first_we: o_WE=%b required 1", name, o_WE);
    end
    for (int c = 0; c < 4000 && !seen_done; c++) begin
      if (o_DONE === 1'b1) begin
        seen_done = 1; cyc++;
        tests++;
        if (o_WE !== 1'b0 || o_BUSY !== 1'b0) begin
          fails++; $display("FAIL %s done_outputs: we=%b busy=%b required 0 0", name, o_WE, o_BUSY);
        end
      end else begin
        if (o_WE === 1'b1) begin
          cyc++; wes++;
          tests++;
          if (idx > int'(last)) begin
            fails++; $display("FAIL %s extra_write: addr=%h after %0d accepted, last=%h", name, o_ADDR, idx, last);
          end else if (o_ADDR !== idx[7:0] || o_DATA !== model_pat(mode, idx)) begin
            fails++; $display("FAIL %s write: addr=%h data=%h required addr=%h data=%h", name, o_ADDR, o_DATA, idx[7:0], model_pat(mode, idx));
          end
        end
        if (o_BUSY === 1'b1) busys++;
        i_READY = rmode == 0 ? 1'b1 : rmode == 1 ? alt : 1'($urandom_range(0, 1));
        alt = ~alt;
        if (o_WE === 1'b1 && i_READY) idx++;
        if (chaos) begin
          i_START = 1'($urandom_range(0, 1)); i_MODE = 1'($urandom); i_ADDR_LAST = 8'($urandom);
        end
        step();
      end
    end
    tests++;
    if (!seen_done || idx != int'(last) + 1) begin
      fails++; $display("FAIL %s completion: done=%b accepted=%0d required done=1 accepted=%0d", name, seen_done, idx, int'(last) + 1);
    end
    tests++;
    if (busys != wes) begin
      fails++; $display("FAIL %s busy_cycles: busy=%0d required %0d", name, busys, wes);
    end
    if (rmode == 0) begin
      tests++;
      if (cyc != int'(last) + 2) begin
        fails++; $display("FAIL %s cycles: %0d required %0d", name, cyc, int'(last) + 2);
      end
    end
    i_START = keep_start; i_MODE = mode; i_ADDR_LAST = last;
    step();
    tests++;
    if (o_DONE !== 1'b0 || o_WE !== 1'b0 || o_BUSY !== 1'b0 || o_ADDR !== last || o_DATA !== model_pat(mode, int'(last))) begin
      fails++;
      $display("FAIL %s post_done: done=%b we=%b busy=%b addr=%h data=%h required 0 0 0 %h %h", name, o_DONE, o_WE, o_BUSY, o_ADDR, o_DATA, last, model_pat(mode, int'(last)));
    end
  endtask

  task automatic test_reset();
    i_RST = 1; i_START = 1; i_MODE = 1; i_ADDR_LAST = 8'h10;
    step(); step();
    check_idle_zero("reset");
    i_RST = 0; i_START = 0;
    step();
    check_idle_zero("reset_release");
  endtask

  task automatic test_walk_ones();
    run_seq(1'b0, 8'd9, 0, 0, 0, "walk_ones");
  endtask

  task automatic test_walk_zeros_stall();
    run_seq(1'b1, 8'd3, 1, 0, 0, "walk_zeros_stall");
  endtask

  task automatic test_last_zero();
    run_seq(1'b0, 8'd0, 0, 0, 0, "last_zero");
  endtask

  task automatic test_last_max();
    run_seq(1'b0, 8'hFF, 0, 0, 0, "last_max");
    step();
    tests++;
    if (o_WE !== 1'b0) begin
      fails++; $display("FAIL last_max no_wrap: o_WE=%b addr=%h required 0", o_WE, o_ADDR);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    i_START = 1; i_MODE = 0; i_ADDR_LAST = 8'd20; i_READY = 1;
    step();
    i_START = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (o_WE === 1'b1 && o_ADDR === 8'd5) found = 1;
      else step();
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL reset_mid reach_addr5: not reached, required addr 05");
    end
    i_RST = 1;
    step();
    check_idle_zero("reset_mid");
    i_RST = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_idle_zero("reset_mid_quiet");
    end
    run_seq(1'b0, 8'd20, 2, 0, 0, "reset_mid_restart");
  endtask

  task automatic test_ignore_inputs();
    run_seq(1'b1, 8'd12, 2, 1, 0, "ignore_inputs_zeros");
    run_seq(1'b0, 8'd17, 0, 1, 0, "ignore_inputs_ones");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_seq(1'($urandom), 8'($urandom_range(0, 40)), 2, 1, 0, "random");
  endtask

  task automatic test_back_to_back();
    run_seq(1'b1, 8'd2, 0, 0, 1, "back_to_back");
    step();
    tests++;
    if (o_WE !== 1'b1 || o_ADDR !== 8'd0 || o_DATA !== 8'hFE) begin
      fails++; $display("FAIL back_to_back restart: we=%b addr=%h data=%h required 1 00 fe", o_WE, o_ADDR, o_DATA);
    end
    i_START = 0; i_RST = 1;
    step();
    check_idle_zero("back_to_back_reset");
    i_RST = 0;
  endtask

  initial begin
    test_reset();
    test_walk_ones();
    test_walk_zeros_stall();
    test_last_zero();
    test_last_max();
    test_reset_mid();
    test_ignore_inputs();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
